bi_mem_wm_arbiter: RTL and testbench

- Round-robin arbiter that shares one BiMemWm port between NUM_REQ requesters.
- Each requester has a valid/ready request channel and a one-cycle response pulse.
- Memory-side ports connect 1:1 to a BiMemWm instance. The arbiter honours the memory's hold output by freezing the grant and the command.
- Sits between bus adapters and a shared scratchpad or instruction memory.

---
 rtl/bi_mem_arb_pkg.sv | 36 +++
 rtl/bi_rr_arbiter.sv | 59 +++++
 rtl/bi_mem_wm_arbiter.sv | 126 ++++++++++++
 tb/tb_bi_mem_wm_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bi_mem_arb_pkg.sv
// Shared types and the round-robin pick function for the BiMemWm arbiter.
// REQ_* widths bound the WIDTH/HEIGHT/MASK parameters of the arbiter; ARB_MAX_REQ bounds NUM_REQ.
package bi_mem_arb_pkg;

  localparam int unsigned ARB_MAX_REQ = 16;
  localparam int unsigned ARB_PTR_W   = $clog2(ARB_MAX_REQ);
  localparam int unsigned REQ_WIDTH   = 16;
  localparam int unsigned REQ_AW      = 4;
  localparam int unsigned REQ_MASK    = 4;

  typedef struct packed {
    logic                 isWrite;
    logic [REQ_MASK-1:0]  writeMask;
    logic [REQ_AW-1:0]    addr;
    logic [REQ_WIDTH-1:0] writeData;
  } req_t;

  // Unused upper valid bits are zero, so wrapping at ARB_MAX_REQ equals wrapping at NUM_REQ.
  function automatic logic [ARB_MAX_REQ-1:0] rr_pick(input logic [ARB_MAX_REQ-1:0] valid,
                                                     input logic [ARB_PTR_W-1:0]   ptr);
    logic [ARB_MAX_REQ-1:0] grant;
    logic [ARB_PTR_W-1:0]   idx;
    logic                   found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      idx = ptr + ARB_PTR_W'(i);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/bi_rr_arbiter.sv
// Generic NUM_REQ round-robin picker with its own pointer, a grant freeze and a pointer advance.
module bi_rr_arbiter
  import bi_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               freeze_i,
  input  logic               release_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_c_o
);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               frozen_q, frozen_d;
  logic [NUM_REQ-1:0] fgrant_q, fgrant_d;
  logic [NUM_REQ-1:0] pick_c, owner_c;
  logic [PTR_W-1:0]   owner_idx_c;

  always_comb begin
    pick_c    = NUM_REQ'(rr_pick(ARB_MAX_REQ'(valid_i), ARB_PTR_W'(ptr_q)));
    // A frozen owner keeps the grant but only asserts it while it is still valid.
    grant_c_o = frozen_q ? (fgrant_q & valid_i) : pick_c;
    owner_c   = frozen_q ? fgrant_q : pick_c;

    owner_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_c[i]) owner_idx_c = PTR_W'(i);
    end

    frozen_d = frozen_q;
    fgrant_d = fgrant_q;
    ptr_d    = ptr_q;
    if (freeze_i) begin
      frozen_d = 1'b1;
      fgrant_d = owner_c;
    end
    if (release_i) frozen_d = 1'b0;
    if (advance_i) begin
      ptr_d = (owner_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx_c + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q    <= '0;
      frozen_q <= 1'b0;
      fgrant_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      frozen_q <= frozen_d;
      fgrant_q <= fgrant_d;
    end
  end

endmodule

// File: rtl/bi_mem_wm_arbiter.sv
// Round-robin arbiter sharing one BiMemWm port between NUM_REQ valid/ready requesters.
// Define BI_MEM_ARB_LOCK_EN to add req_lock_i for locked multi-transfer grants.
module bi_mem_wm_arbiter
  import bi_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = REQ_WIDTH,
  parameter int unsigned HEIGHT  = 16,
  parameter int unsigned MASK    = REQ_MASK,
  localparam int unsigned AW     = $clog2(HEIGHT)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       req_isWrite_i,
  input  logic [NUM_REQ*MASK-1:0]  req_writeMask_i,
  input  logic [NUM_REQ*AW-1:0]    req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_writeData_i,
`ifdef BI_MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock_i,
`endif
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic                     mem_enable_o,
  output logic                     mem_isWrite_o,
  output logic [MASK-1:0]          mem_writeMask_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [WIDTH-1:0]         mem_writeData_o,
  input  logic [WIDTH-1:0]         mem_readData_i,
  input  logic                     mem_hold_i
);

  logic [NUM_REQ-1:0] grant_raw_c, grant_c, xfer_c;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               enable_c, accept_c;
  logic               freeze_c, release_c, advance_c;
  req_t               sel_c;

  bi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .valid_i   (req_valid_i),
    .freeze_i  (freeze_c),
    .release_i (release_c),
    .advance_i (advance_c),
    .grant_c_o (grant_raw_c)
  );

  // Command mux: winner's fields onto the memory port, zero when idle or in reset.
  always_comb begin
    grant_c = reset_i ? '0 : grant_raw_c;
    sel_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        sel_c.isWrite   = req_isWrite_i[i];
        sel_c.writeMask = REQ_MASK'(req_writeMask_i[i*MASK +: MASK]);
        sel_c.addr      = REQ_AW'(req_addr_i[i*AW +: AW]);
        sel_c.writeData = REQ_WIDTH'(req_writeData_i[i*WIDTH +: WIDTH]);
      end
    end
    enable_c        = |grant_c;
    mem_enable_o    = enable_c;
    mem_isWrite_o   = sel_c.isWrite;
    mem_writeMask_o = sel_c.isWrite ? MASK'(sel_c.writeMask) : '0;
    mem_addr_o      = AW'(sel_c.addr);
    mem_writeData_o = WIDTH'(sel_c.writeData);
    req_ready_o     = grant_c & {NUM_REQ{~mem_hold_i}};
    xfer_c          = req_valid_i & req_ready_o;
    accept_c        = |xfer_c;
    rsp_valid_d     = xfer_c;
    rsp_valid_o     = rsp_valid_q;
    rsp_data_o      = mem_readData_i;
  end

`ifdef BI_MEM_ARB_LOCK_EN
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic               lock_w_c, lock_acc_c, idle_rel_c;

  // A locked owner keeps the grant frozen; the pointer moves only when the lock lets go.
  always_comb begin
    lock_w_c   = |(grant_c & req_lock_i);
    lock_acc_c = accept_c & lock_w_c;
    idle_rel_c = lock_q & ~|(owner_q & req_valid_i) & ~|rsp_valid_q;
    freeze_c   = (enable_c & mem_hold_i) | lock_acc_c;
    release_c  = (accept_c & ~lock_w_c) | idle_rel_c;
    advance_c  = release_c;
    lock_d     = lock_q;
    owner_d    = owner_q;
    if (lock_acc_c) begin
      lock_d  = 1'b1;
      owner_d = grant_c;
    end else if (release_c) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  always_comb begin
    freeze_c  = enable_c & mem_hold_i;
    release_c = accept_c;
    advance_c = accept_c;
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rsp_valid_q <= '0;
    else         rsp_valid_q <= rsp_valid_d;
  end

  // A held requester must present the same command until it is accepted.
  a_hold_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (mem_enable_o && mem_hold_i) |=> (mem_enable_o &&
      $stable({mem_isWrite_o, mem_writeMask_o, mem_addr_o, mem_writeData_o})));

endmodule

// File: tb/tb_bi_mem_wm_arbiter.sv
// Directed self-checking bench for bi_mem_wm_arbiter (3 requesters) with a small BiMemWm model.
module tb_bi_mem_wm_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned AB = 4;
  localparam int unsigned M  = 4;

  logic           clk, reset;
  logic [N-1:0]   req_valid, req_ready, req_isWrite, rsp_valid;
  logic [N*M-1:0] req_mask;
  logic [N*AB-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [W-1:0]   rsp_data, mem_wdata, rd_q;
  logic           mem_enable, mem_isWrite, mem_hold;
  logic [M-1:0]   mem_mask;
  logic [AB-1:0]  mem_addr;
`ifdef BI_MEM_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif

  int tests = 0;
  int fails = 0;

  bi_mem_wm_arbiter #(.NUM_REQ(N), .WIDTH(W), .HEIGHT(16), .MASK(M)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_isWrite_i   (req_isWrite),
    .req_writeMask_i (req_mask),
    .req_addr_i      (req_addr),
    .req_writeData_i (req_wdata),
`ifdef BI_MEM_ARB_LOCK_EN
    .req_lock_i      (req_lock),
`endif
    .rsp_valid_o     (rsp_valid),
    .rsp_data_o      (rsp_data),
    .mem_enable_o    (mem_enable),
    .mem_isWrite_o   (mem_isWrite),
    .mem_writeMask_o (mem_mask),
    .mem_addr_o      (mem_addr),
    .mem_writeData_o (mem_wdata),
    .mem_readData_i  (rd_q),
    .mem_hold_i      (mem_hold)
  );

  always #5 clk = ~clk;

  // BiMemWm model: nibble-lane write mask, one-cycle read latency, stalls on hold.
  logic [W-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_enable && !mem_hold) begin
      if (mem_isWrite) begin
        for (int k = 0; k < 4; k++)
          if (mem_mask[k]) mem_arr[mem_addr][4*k +: 4] <= mem_wdata[4*k +: 4];
      end else begin
        rd_q <= mem_arr[mem_addr];
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic wr, input logic [3:0] m,
                         input logic [3:0] a, input logic [15:0] d);
    req_valid[i]         = v;
    req_isWrite[i]       = wr;
    req_mask[i*4 +: 4]   = m;
    req_addr[i*4 +: 4]   = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic clear_reqs();
    req_valid   = '0;
    req_isWrite = '0;
    req_mask    = '0;
    req_addr    = '0;
    req_wdata   = '0;
`ifdef BI_MEM_ARB_LOCK_EN
    req_lock    = '0;
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    mem_hold = 1'b0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    set_req(0, 1'b1, 1'b1, 4'hF, 4'h5, 16'hAAAA);
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL reset_rsp got %b exp 000", rsp_valid); end
    tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    tests++; if (mem_enable !== 1'b0) begin fails++; $display("FAIL reset_enable got %b exp 0", mem_enable); end
    tests++; if (mem_addr !== 4'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    tests++; if (mem_wdata !== 16'h0) begin fails++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
    next_cycle();
    clear_reqs();
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(0, 1'b1, 1'b1, 4'hF, 4'h3, 16'hBEEF);
    @(negedge clk);
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL wr_ready got %b exp 001", req_ready); end
    tests++; if ({mem_enable, mem_isWrite, mem_mask, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'hF, 4'h3, 16'hBEEF}) begin
      fails++; $display("FAIL wr_cmd got en=%b wr=%b m=%h a=%h d=%h exp 1 1 f 3 beef", mem_enable, mem_isWrite, mem_mask, mem_addr, mem_wdata); end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 4'hF, 4'h3, 16'h0000);
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b001) begin fails++; $display("FAIL wr_ack got %b exp 001", rsp_valid); end
    tests++; if (mem_mask !== 4'h0) begin fails++; $display("FAIL rd_mask_forced got %h exp 0", mem_mask); end
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rd_ready got %b exp 001", req_ready); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b001) begin fails++; $display("FAIL rd_rsp got %b exp 001", rsp_valid); end
    tests++; if (rsp_data !== 16'hBEEF) begin fails++; $display("FAIL rd_data got %h exp beef", rsp_data); end
    tests++; if (mem_enable !== 1'b0) begin fails++; $display("FAIL idle_enable got %b exp 0", mem_enable); end
    next_cycle();
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL rsp_single got %b exp 000", rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [2:0] er, ersp;
    logic [3:0] ea;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 4'h0, 4'(4 + i), 16'h0);
    for (int k = 0; k < 9; k++) begin
      er   = 3'b001 << (k % 3);
      ersp = (k == 0) ? 3'b000 : (3'b001 << ((k - 1) % 3));
      ea   = 4'(4 + (k % 3));
      @(negedge clk);
      tests++; if (req_ready !== er) begin fails++; $display("FAIL fair_grant[%0d] got %b exp %b", k, req_ready, er); end
      tests++; if (rsp_valid !== ersp) begin fails++; $display("FAIL fair_rsp[%0d] got %b exp %b", k, rsp_valid, ersp); end
      tests++; if (mem_addr !== ea) begin fails++; $display("FAIL fair_addr[%0d] got %h exp %h", k, mem_addr, ea); end
      next_cycle();
    end
    clear_reqs();
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b100) begin fails++; $display("FAIL fair_last_rsp got %b exp 100", rsp_valid); end
    next_cycle();
  endtask

  task automatic test_hold();
    do_reset();
    set_req(1, 1'b1, 1'b0, 4'h0, 4'h7, 16'h0);
    mem_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_req(0, 1'b1, 1'b0, 4'h0, 4'h2, 16'h0);
      @(negedge clk);
      tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL hold_ready[%0d] got %b exp 000", c, req_ready); end
      tests++; if ({mem_enable, mem_addr} !== {1'b1, 4'h7}) begin fails++; $display("FAIL hold_cmd[%0d] got en=%b a=%h exp 1 7", c, mem_enable, mem_addr); end
      next_cycle();
    end
    mem_hold = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL hold_release got %b exp 010", req_ready); end
    next_cycle();
    set_req(1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0);
    @(negedge clk);
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL hold_next got %b exp 001", req_ready); end
    tests++; if (rsp_valid !== 3'b010) begin fails++; $display("FAIL hold_rsp got %b exp 010", rsp_valid); end
    tests++; if (mem_addr !== 4'h2) begin fails++; $display("FAIL hold_next_addr got %h exp 2", mem_addr); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b001) begin fails++; $display("FAIL hold_next_rsp got %b exp 001", rsp_valid); end
    next_cycle();
  endtask

  task automatic test_masked_write();
    do_reset();
    set_req(2, 1'b1, 1'b1, 4'hF, 4'h9, 16'hFFFF);
    next_cycle();
    set_req(2, 1'b1, 1'b1, 4'b0011, 4'h9, 16'h1234);
    @(negedge clk);
    tests++; if (mem_mask !== 4'b0011) begin fails++; $display("FAIL mask_out got %b exp 0011", mem_mask); end
    tests++; if (rsp_valid !== 3'b100) begin fails++; $display("FAIL mask_ack got %b exp 100", rsp_valid); end
    next_cycle();
    set_req(2, 1'b1, 1'b0, 4'h0, 4'h9, 16'h0);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b100) begin fails++; $display("FAIL mask_rsp got %b exp 100", rsp_valid); end
    tests++; if (rsp_data !== 16'hFF34) begin fails++; $display("FAIL mask_data got %h exp ff34", rsp_data); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 1'b1, 1'b0, 4'h0, 4'h9, 16'h0);
    @(negedge clk);
    tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL rmid_ready got %b exp 010", req_ready); end
    next_cycle();
    clear_reqs();
    tests++; if (rsp_valid !== 3'b010) begin fails++; $display("FAIL rmid_pending got %b exp 010", rsp_valid); end
    reset = 1'b1;
    #1;
    tests++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL rmid_async got %b exp 000", rsp_valid); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL rmid_after got %b exp 000", rsp_valid); end
    next_cycle();
    set_req(1, 1'b1, 1'b0, 4'h0, 4'h1, 16'h0);
    set_req(2, 1'b1, 1'b0, 4'h0, 4'h2, 16'h0);
    @(negedge clk);
    tests++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL rmid_nopulse got %b exp 000", rsp_valid); end
    tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL rmid_ptr got %b exp 010", req_ready); end
    next_cycle();
    clear_reqs();
    next_cycle();
  endtask

`ifdef BI_MEM_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_req(2, 1'b1, 1'b0, 4'h0, 4'h1, 16'h0);
    req_lock[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) set_req(0, 1'b1, 1'b0, 4'h0, 4'h2, 16'h0);
      if (c == 3) req_lock[2] = 1'b0;
      @(negedge clk);
      tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL lock_grant[%0d] got %b exp 100", c, req_ready); end
      next_cycle();
    end
    @(negedge clk);
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL lock_release got %b exp 001", req_ready); end
    tests++; if (rsp_valid !== 3'b100) begin fails++; $display("FAIL lock_rsp got %b exp 100", rsp_valid); end
    next_cycle();
    clear_reqs();
    next_cycle();
  endtask
`endif

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    mem_hold = 1'b0;
    clear_reqs();
    test_reset();
    test_write_read();
    test_fairness();
    test_hold();
    test_masked_write();
    test_reset_mid();
`ifdef BI_MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
